// File: rtl/btn_irq_gateway.sv
// Push-button to PLIC interrupt gateway: synchronizes and debounces BTND, emits one
// press pulse per accepted press, and queues presses behind an IDLE/PENDING/IN_SERVICE handshake.
module btn_irq_gateway #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_PEND        = 7
) (
    input  logic       CLK100MHZ,
    input  logic       BTNC,
    input  logic       BTND,
    input  logic       claim_i,
    input  logic       complete_i,
    output logic       irq_o,
    output logic       press_o,
    output logic [2:0] pend_o,
    output logic [3:0] press_count_o
);
    localparam logic [15:0] DCNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]  PEND_MAX  = 3'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PENDING    = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        meta;
    logic        sync;
    logic        db;
    logic        db_prev;
    logic [15:0] dcnt;
    logic [2:0]  pend_next;
    logic        claim_ok;

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= BTND;
            sync <= meta;
        end
    end

    // dcnt counts consecutive samples disagreeing with db; db flips on the last one
    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            db      <= 1'b0;
            db_prev <= 1'b0;
            dcnt    <= '0;
            press_o <= 1'b0;
        end else begin
            db_prev <= db;
            press_o <= db & ~db_prev;
            if (sync == db) begin
                dcnt <= '0;
            end else if (dcnt == DCNT_LAST) begin
                db   <= sync;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 16'd1;
            end
        end
    end

    always_comb begin
        claim_ok  = (state == PENDING) && claim_i;
        pend_next = pend_o;
        if (press_o && claim_ok) begin
            // a press arriving at saturation is dropped, so the claim still removes one
            if (pend_o == PEND_MAX) begin
                pend_next = PEND_MAX - 3'd1;
            end
        end else if (press_o) begin
            if (pend_o != PEND_MAX) begin
                pend_next = pend_o + 3'd1;
            end
        end else if (claim_ok && (pend_o != 3'd0)) begin
            pend_next = pend_o - 3'd1;
        end

        state_next = state;
        case (state)
            IDLE: begin
                if ((pend_o != 3'd0) || press_o) begin
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (claim_i) begin
                    state_next = IN_SERVICE;
                end
            end
            IN_SERVICE: begin
                if (complete_i) begin
                    state_next = (pend_next != 3'd0) ? PENDING : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            state         <= IDLE;
            pend_o        <= 3'd0;
            irq_o         <= 1'b0;
            press_count_o <= 4'd0;
        end else begin
            state         <= state_next;
            pend_o        <= pend_next;
            irq_o         <= (state_next == PENDING);
            press_count_o <= press_count_o + {3'd0, press_o};
        end
    end

endmodule

// File: tb/tb_btn_irq_gateway.sv
// Bench for btn_irq_gateway: directed table, hand-written corner sequences and a
// random run, all checked each cycle against a sample-history reference model.
module tb_btn_irq_gateway;
    localparam int D    = 4;
    localparam int MAXP = 7;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       btnd     = 1'b0;
    logic       claim    = 1'b0;
    logic       complete = 1'b0;
    logic       irq;
    logic       press;
    logic [2:0] pend;
    logic [3:0] cnt;

    int vectors     = 0;
    int miscompares = 0;

    btn_irq_gateway #(.DEBOUNCE_CYCLES(D), .MAX_PEND(MAXP)) dut (
        .CLK100MHZ     (clk),
        .BTNC          (rst),
        .BTND          (btnd),
        .claim_i       (claim),
        .complete_i    (complete),
        .irq_o         (irq),
        .press_o       (press),
        .pend_o        (pend),
        .press_count_o (cnt)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples, synchronized samples and debounced history as queues
    bit btn_q[$];
    bit sync_q[$];
    bit db_q[$];
    bit m_press;
    bit m_irq;
    int m_pend;
    int m_phase;      // 0 idle, 1 waiting for claim, 2 being serviced
    int m_presses;

    function automatic void model_reset();
        btn_q.delete();
        sync_q.delete();
        db_q.delete();
        db_q.push_back(1'b0);
        db_q.push_back(1'b0);
        m_press   = 1'b0;
        m_irq     = 1'b0;
        m_pend    = 0;
        m_phase   = 0;
        m_presses = 0;
    endfunction

    function automatic void model_step();
        bit sync_now;
        bit db_now;
        bit agree;
        bit press_new;
        int p;
        int phase;
        sync_now = (btn_q.size() >= 2) ? btn_q[btn_q.size() - 2] : 1'b0;
        btn_q.push_back(btnd);
        if (btn_q.size() > 2) void'(btn_q.pop_front());
        sync_q.push_back(sync_now);
        if (sync_q.size() > D) void'(sync_q.pop_front());
        press_new = db_q[1] && !db_q[0];
        db_now    = db_q[1];
        // the level moves only after D samples in a row that all disagree with it
        if (sync_q.size() == D) begin
            agree = 1'b0;
            foreach (sync_q[i]) if (sync_q[i] == db_now) agree = 1'b1;
            if (!agree) db_now = sync_now;
        end
        db_q.push_back(db_now);
        void'(db_q.pop_front());

        p = m_pend + int'(m_press);
        if (p > MAXP) p = MAXP;
        if (m_phase == 1 && claim) p = p - 1;
        phase = m_phase;
        case (m_phase)
            0:       if (m_pend != 0 || m_press) phase = 1;
            1:       if (claim) phase = 2;
            default: if (complete) phase = (p != 0) ? 1 : 0;
        endcase
        m_presses += int'(m_press);
        m_press = press_new;
        m_pend  = p;
        m_phase = phase;
        m_irq   = (phase == 1);
    endfunction

    task automatic check_model(string tag);
        vectors++;
        if (press !== m_press || irq !== m_irq || pend !== 3'(m_pend) || cnt !== 4'(m_presses)) begin
            miscompares++;
            $display("FAIL model/%s t=%0t: got press=%0b irq=%0b pend=%0d cnt=%0d, want press=%0b irq=%0b pend=%0d cnt=%0d",
                     tag, $time, press, irq, pend, cnt, m_press, m_irq, m_pend, m_presses % 16);
        end
    endtask

    task automatic expect_out(string name, bit e_press, bit e_irq, int e_pend, int e_cnt);
        vectors++;
        if (press !== e_press || irq !== e_irq || pend !== 3'(e_pend) || cnt !== 4'(e_cnt)) begin
            miscompares++;
            $display("FAIL %s t=%0t: got press=%0b irq=%0b pend=%0d cnt=%0d, want press=%0b irq=%0b pend=%0d cnt=%0d",
                     name, $time, press, irq, pend, cnt, e_press, e_irq, e_pend, e_cnt);
        end
    endtask

    task automatic expect_val(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic tick(string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        btnd     = 1'b0;
        claim    = 1'b0;
        complete = 1'b0;
        rst      = 1'b1;
        repeat (3) tick("in_reset");
        rst = 1'b0;
    endtask

    task automatic press_btn(int hold, int gap);
        btnd = 1'b1;
        repeat (hold) tick("press_hold");
        btnd = 1'b0;
        repeat (gap) tick("press_gap");
    endtask

    typedef struct {
        bit btnd;
        bit claim;
        bit complete;
        bit press;
        bit irq;
        int pend;
        int cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int saw;
        int guard;
        int hold;

        // clean press at row 0, handshake, ignored claim/complete, release
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{btnd: (i < 11), claim: (i == 8 || i == 9), complete: (i == 10 || i == 11),
                       press: (i == 6), irq: (i == 7), pend: ((i == 7) ? 1 : 0), cnt: ((i >= 7) ? 1 : 0)};
        end

        model_reset();
        repeat (3) tick("init_reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            btnd     = tbl[i].btnd;
            claim    = tbl[i].claim;
            complete = tbl[i].complete;
            tick("table");
            expect_out($sformatf("table_row%0d", i), tbl[i].press, tbl[i].irq, tbl[i].pend, tbl[i].cnt);
        end
        claim    = 1'b0;
        complete = 1'b0;

        // bounce: 2-cycle pulses never accepted
        do_reset();
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            btnd = (i % 2 == 0);
            repeat (2) begin
                tick("bounce");
                if (press === 1'b1) saw++;
            end
        end
        btnd = 1'b0;
        repeat (10) begin
            tick("bounce_low");
            if (press === 1'b1) saw++;
        end
        expect_val("bounce_press", saw, 0);
        expect_out("bounce_idle", 1'b0, 1'b0, 0, 0);

        // saturation and counter wrap
        do_reset();
        repeat (9) press_btn(8, 8);
        expect_out("sat9", 1'b0, 1'b1, 7, 9);
        repeat (8) press_btn(8, 8);
        expect_out("wrap17", 1'b0, 1'b1, 7, 1);

        // press coinciding with claim at pend=2
        do_reset();
        repeat (2) press_btn(8, 8);
        expect_out("sim_setup", 1'b0, 1'b1, 2, 2);
        btnd  = 1'b1;
        guard = 0;
        while (press !== 1'b1 && guard < 20) begin
            tick("sim_wait");
            guard++;
        end
        expect_val("sim_press_seen", int'(press === 1'b1), 1);
        claim = 1'b1;
        tick("sim_claim");
        claim = 1'b0;
        expect_out("sim_claim", 1'b0, 1'b0, 2, 3);
        btnd = 1'b0;
        repeat (8) tick("sim_gap");
        complete = 1'b1;
        tick("sim_complete");
        complete = 1'b0;
        expect_out("sim_complete", 1'b0, 1'b1, 2, 3);

        // mid-cycle reset while in service and mid-debounce, held 1500 ns
        do_reset();
        press_btn(8, 2);
        claim = 1'b1;
        tick("rst_claim");
        claim = 1'b0;
        btnd  = 1'b1;
        repeat (3) tick("rst_debounce");
        #2;
        rst = 1'b1;
        #1;
        expect_out("reset_async", 1'b0, 1'b0, 0, 0);
        repeat (150) tick("reset_hold");
        #2;
        rst = 1'b0;
        for (int i = 1; i <= D + 4; i++) begin
            tick("post_reset");
            expect_val($sformatf("post_reset_press_c%0d", i), int'(press === 1'b1), int'(i == D + 3));
        end
        repeat (3) tick("post_reset_tail");
        expect_out("post_reset_irq", 1'b0, 1'b1, 1, 1);

        // random traffic with occasional resets
        do_reset();
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                btnd = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 10));
            end
            hold--;
            claim    = ($urandom_range(0, 3) == 0);
            complete = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 399) == 0);
            tick("random");
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
